// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: read-owner encoding and starvation limit.
package mem_arb_pkg;

    localparam int unsigned DEF_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_AUX  = 2'd2
    } owner_e;

    // Counter width able to hold 0..max_val (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core, aux and single-port memory signals of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    // Core MEM-stage port
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic              c_busy;
    logic [DATA_W-1:0] c_rdata;

    // Aux (loader/DMA) port
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    // Single-port memory command and read return
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    // Arbiter view
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  a_req, a_we, a_addr, a_wdata,
        input  m_rdata,
        output c_gnt, c_rvalid, c_busy, c_rdata,
        output a_gnt, a_rvalid, a_rdata,
        output m_en, m_we, m_addr, m_wdata
    );

    // Requesters plus memory view
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output a_req, a_we, a_addr, a_wdata,
        output m_rdata,
        input  c_gnt, c_rvalid, c_busy, c_rdata,
        input  a_gnt, a_rvalid, a_rdata,
        input  m_en, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the aux requester has been refused.
module starve_counter
    import mem_arb_pkg::*;
#(
    parameter  int unsigned MAX_WAIT = DEF_MAX_WAIT,
    localparam int unsigned CNT_W    = cnt_width(MAX_WAIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_at_max
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_count;

    // Clear wins over increment; hold once the limit is reached
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_CNT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_at_max = (r_count == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory: core has priority,
// aux is forced through after MAX_WAIT refused cycles.
module dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = cnt_width(MAX_WAIT);

    logic              w_c_gnt;
    logic              w_a_gnt;
    logic              w_at_max;
    logic              w_inc;
    logic              w_clr;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_m_we;
    logic [ADDR_W-1:0] w_m_addr;
    logic [DATA_W-1:0] w_m_wdata;
    logic              w_c_rvalid;
    logic              w_a_rvalid;
    owner_e            w_owner_nxt;
    owner_e            r_owner;
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_a_rdata;

    // Grant selection: aux wins when core is idle or aux has hit the wait limit
    always_comb begin
        w_c_gnt = 1'b0;
        w_a_gnt = 1'b0;
        if (!rst) begin
            w_a_gnt = bus.a_req && (!bus.c_req || w_at_max);
            w_c_gnt = bus.c_req && !w_a_gnt;
        end
    end

    assign w_inc = bus.a_req && !w_a_gnt;
    assign w_clr = !bus.a_req || w_a_gnt;

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_inc),
        .i_clr    (w_clr),
        .o_count  (w_cnt),
        .o_at_max (w_at_max)
    );

    // Memory command mux from the granted requester; zeros when idle
    always_comb begin
        w_m_we    = 1'b0;
        w_m_addr  = '0;
        w_m_wdata = '0;
        if (w_c_gnt) begin
            w_m_we    = bus.c_we;
            w_m_addr  = bus.c_addr;
            w_m_wdata = bus.c_wdata;
        end else if (w_a_gnt) begin
            w_m_we    = bus.a_we;
            w_m_addr  = bus.a_addr;
            w_m_wdata = bus.a_wdata;
        end
    end

    // Remember who issued this cycle's read so the return is routed next cycle
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_c_gnt && !bus.c_we) begin
            w_owner_nxt = OWN_CORE;
        end else if (w_a_gnt && !bus.a_we) begin
            w_owner_nxt = OWN_AUX;
        end
    end

    // Owner register; reset discards a read granted in the reset cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    assign w_c_rvalid = (r_owner == OWN_CORE);
    assign w_a_rvalid = (r_owner == OWN_AUX);

    // Read-data hold registers keep the last returned word per requester
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_rdata <= '0;
            r_a_rdata <= '0;
        end else begin
            if (w_c_rvalid) begin
                r_c_rdata <= bus.m_rdata;
            end
            if (w_a_rvalid) begin
                r_a_rdata <= bus.m_rdata;
            end
        end
    end

    assign bus.c_gnt    = w_c_gnt;
    assign bus.a_gnt    = w_a_gnt;
    assign bus.c_busy   = bus.c_req && !w_c_gnt;
    assign bus.m_en     = w_c_gnt || w_a_gnt;
    assign bus.m_we     = w_m_we;
    assign bus.m_addr   = w_m_addr;
    assign bus.m_wdata  = w_m_wdata;
    assign bus.c_rvalid = w_c_rvalid;
    assign bus.a_rvalid = w_a_rvalid;
    assign bus.c_rdata  = w_c_rvalid ? bus.m_rdata : r_c_rdata;
    assign bus.a_rdata  = w_a_rvalid ? bus.m_rdata : r_a_rdata;

    // Sanity: grants are exclusive and the wait count never passes its limit
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_c_gnt && w_a_gnt));
            assert (w_cnt <= CNT_W'(MAX_WAIT));
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus starvation/reset sequences.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed memory contents seen by reads
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h04:  return 32'h1111_1111;
            32'h08:  return 32'h2222_2222;
            32'h0C:  return 32'h3333_3333;
            32'h10:  return 32'hDEAD_BEEF;
            default: return 32'hC0DE_0000 | a;
        endcase
    endfunction

    // Memory model: read data one cycle after a read command, junk otherwise
    always @(posedge clk) begin
        if (bus.m_en && !bus.m_we) bus.m_rdata <= rom(bus.m_addr);
        else                       bus.m_rdata <= 32'hBAD0_BAD0;
    end

    typedef struct {
        string       name;
        logic        rst;
        logic        c_req;
        logic        c_we;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic        a_req;
        logic        a_we;
        logic [31:0] a_addr;
        logic [31:0] a_wdata;
        logic        e_c_gnt;
        logic        e_a_gnt;
        logic        e_c_busy;
        logic        e_m_en;
        logic        e_m_we;
        logic [31:0] e_m_addr;
        logic [31:0] e_m_wdata;
        logic        e_c_rvalid;
        logic        e_a_rvalid;
        logic [31:0] e_c_rdata;
        logic [31:0] e_a_rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else             n_pass++;
    endtask

    task automatic drive(input logic r,
                         input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad);
        rst         = r;
        bus.c_req   = cr;
        bus.c_we    = cw;
        bus.c_addr  = ca;
        bus.c_wdata = cd;
        bus.a_req   = ar;
        bus.a_we    = aw;
        bus.a_addr  = aa;
        bus.a_wdata = ad;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        //          name       rst  c: req we addr   wdata  a: req we addr   wdata   exp: cg ag bsy en we addr   wdata  crv arv c_rdata        a_rdata
        vecs[0]  = '{"rst_gate", 1,  1, 0, 32'h10, 32'h0,  0, 0, 32'h0,  32'h0,   0, 0, 1, 0, 0, 32'h0,  32'h0,  0, 0, 32'h0,         32'h0};
        vecs[1]  = '{"c_rd10",   0,  1, 0, 32'h10, 32'h0,  0, 0, 32'h0,  32'h0,   1, 0, 0, 1, 0, 32'h10, 32'h0,  0, 0, 32'h0,         32'h0};
        vecs[2]  = '{"c_rv10",   0,  0, 0, 32'h0,  32'h0,  0, 0, 32'h0,  32'h0,   0, 0, 0, 0, 0, 32'h0,  32'h0,  1, 0, 32'hDEADBEEF,  32'h0};
        vecs[3]  = '{"c_hold",   0,  0, 0, 32'h0,  32'h0,  0, 0, 32'h0,  32'h0,   0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 0, 32'hDEADBEEF,  32'h0};
        vecs[4]  = '{"c_rd04",   0,  1, 0, 32'h04, 32'h0,  0, 0, 32'h0,  32'h0,   1, 0, 0, 1, 0, 32'h04, 32'h0,  0, 0, 32'hDEADBEEF,  32'h0};
        vecs[5]  = '{"a_rd08",   0,  0, 0, 32'h0,  32'h0,  1, 0, 32'h08, 32'h0,   0, 1, 0, 1, 0, 32'h08, 32'h0,  1, 0, 32'h11111111,  32'h0};
        vecs[6]  = '{"c_rd0C",   0,  1, 0, 32'h0C, 32'h0,  0, 0, 32'h0,  32'h0,   1, 0, 0, 1, 0, 32'h0C, 32'h0,  0, 1, 32'h11111111,  32'h22222222};
        vecs[7]  = '{"a_wr20",   0,  0, 0, 32'h0,  32'h0,  1, 1, 32'h20, 32'h55,  0, 1, 0, 1, 1, 32'h20, 32'h55, 1, 0, 32'h33333333,  32'h22222222};
        vecs[8]  = '{"idle_wr",  0,  0, 0, 32'h0,  32'h0,  0, 0, 32'h0,  32'h0,   0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 0, 32'h33333333,  32'h22222222};
        vecs[9]  = '{"c_wr24",   0,  1, 1, 32'h24, 32'h77, 0, 0, 32'h0,  32'h0,   1, 0, 0, 1, 1, 32'h24, 32'h77, 0, 0, 32'h33333333,  32'h22222222};
        vecs[10] = '{"both_rd",  0,  1, 0, 32'h04, 32'h0,  1, 0, 32'h08, 32'hAA,  1, 0, 0, 1, 0, 32'h04, 32'h0,  0, 0, 32'h33333333,  32'h22222222};
        vecs[11] = '{"c_rv04",   0,  0, 0, 32'h0,  32'h0,  0, 0, 32'h0,  32'h0,   0, 0, 0, 0, 0, 32'h0,  32'h0,  1, 0, 32'h11111111,  32'h22222222};

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Table: one vector per cycle, state carries across rows
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst, vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wdata,
                  vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wdata);
            #4;
            chk({vecs[i].name, ".c_gnt"},    32'(bus.c_gnt),    32'(vecs[i].e_c_gnt));
            chk({vecs[i].name, ".a_gnt"},    32'(bus.a_gnt),    32'(vecs[i].e_a_gnt));
            chk({vecs[i].name, ".c_busy"},   32'(bus.c_busy),   32'(vecs[i].e_c_busy));
            chk({vecs[i].name, ".m_en"},     32'(bus.m_en),     32'(vecs[i].e_m_en));
            chk({vecs[i].name, ".m_we"},     32'(bus.m_we),     32'(vecs[i].e_m_we));
            chk({vecs[i].name, ".m_addr"},   bus.m_addr,        vecs[i].e_m_addr);
            chk({vecs[i].name, ".m_wdata"},  bus.m_wdata,       vecs[i].e_m_wdata);
            chk({vecs[i].name, ".c_rvalid"}, 32'(bus.c_rvalid), 32'(vecs[i].e_c_rvalid));
            chk({vecs[i].name, ".a_rvalid"}, 32'(bus.a_rvalid), 32'(vecs[i].e_a_rvalid));
            chk({vecs[i].name, ".c_rdata"},  bus.c_rdata,       vecs[i].e_c_rdata);
            chk({vecs[i].name, ".a_rdata"},  bus.a_rdata,       vecs[i].e_a_rdata);
            next_cycle();
        end

        // Both requesting continuously: aux forced through every 5th cycle
        for (int k = 0; k < 10; k++) begin
            logic exp_a;
            logic prev_a;
            exp_a  = ((k % 5) == 4);
            prev_a = (k > 0) && (((k - 1) % 5) == 4);
            drive(0, 1, 0, 32'h04, 0, 1, 0, 32'h08, 0);
            #4;
            chk($sformatf("starve%0d.c_gnt", k),  32'(bus.c_gnt),  32'(!exp_a));
            chk($sformatf("starve%0d.a_gnt", k),  32'(bus.a_gnt),  32'(exp_a));
            chk($sformatf("starve%0d.c_busy", k), 32'(bus.c_busy), 32'(exp_a));
            chk($sformatf("starve%0d.m_addr", k), bus.m_addr,      exp_a ? 32'h08 : 32'h04);
            chk($sformatf("starve%0d.c_rvalid", k), 32'(bus.c_rvalid), 32'((k > 0) && !prev_a));
            chk($sformatf("starve%0d.a_rvalid", k), 32'(bus.a_rvalid), 32'(prev_a));
            if (bus.a_rvalid) chk($sformatf("starve%0d.a_rdata", k), bus.a_rdata, 32'h22222222);
            if (bus.c_rvalid) chk($sformatf("starve%0d.c_rdata", k), bus.c_rdata, 32'h11111111);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        chk("starve_tail.a_rvalid", 32'(bus.a_rvalid), 32'd1);
        chk("starve_tail.c_rvalid", 32'(bus.c_rvalid), 32'd0);
        next_cycle();

        // Aux drops after 3 refusals; count restarts and needs 4 more refusals
        begin
            logic pat_req[9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
            logic pat_gnt[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
            for (int k = 0; k < 9; k++) begin
                drive(0, 1, 0, 32'h04, 0, pat_req[k], 0, 32'h08, 0);
                #4;
                chk($sformatf("restart%0d.a_gnt", k), 32'(bus.a_gnt), 32'(pat_gnt[k]));
                chk($sformatf("restart%0d.c_gnt", k), 32'(bus.c_gnt), 32'(!pat_gnt[k]));
                next_cycle();
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        // Reset right after a core read grant, with aux already waiting
        drive(0, 1, 0, 32'h10, 0, 1, 0, 32'h08, 0);
        #4;
        chk("rstseq.grant_c", 32'(bus.c_gnt), 32'd1);
        next_cycle();
        drive(1, 1, 0, 32'h10, 0, 1, 0, 32'h08, 0);
        #4;
        chk("rstseq.in_rst_c_gnt", 32'(bus.c_gnt), 32'd0);
        chk("rstseq.in_rst_a_gnt", 32'(bus.a_gnt), 32'd0);
        chk("rstseq.in_rst_m_en",  32'(bus.m_en),  32'd0);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 32'h10, 0, 1, 0, 32'h08, 0);
            #4;
            if (k == 0) begin
                chk("rstseq.c_rvalid", 32'(bus.c_rvalid), 32'd0);
                chk("rstseq.a_rvalid", 32'(bus.a_rvalid), 32'd0);
                chk("rstseq.c_rdata",  bus.c_rdata,       32'h0);
                chk("rstseq.a_rdata",  bus.a_rdata,       32'h0);
            end
            if (k == 1) begin
                chk("rstseq.post_c_rvalid", 32'(bus.c_rvalid), 32'd1);
                chk("rstseq.post_c_rdata",  bus.c_rdata,       32'hDEADBEEF);
            end
            chk($sformatf("rstseq%0d.a_gnt", k), 32'(bus.a_gnt), 32'(k == 4));
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
